// File: rtl/stall_controller.sv
// D-cache miss sequencer: victim writeback, refill, cache update; freezes the pipeline while busy.
// Outputs are valid in the first cycle of each state; no stall when the request hits; waits on mem_ready_i indefinitely.
module stall_controller #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             MemRead_i,
  input  logic             MemWrite_i,
  input  logic             hit_i,
  input  logic             dirty_i,
  input  logic             mem_ready_i,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic             cache_we_o,
  output logic             stall_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] miss_cnt_o
);

  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, UPDATE} state_t;

  localparam logic [7:0] TO_LIM = TIMEOUT_CYCLES[7:0];

  state_t     state;
  state_t     next_state;
  logic [7:0] wait_cnt;
  logic [7:0] wait_cnt_nxt;
  logic       timeout_nxt;
  logic       miss;
  logic       in_wait;
  logic       enter_wait;
  logic       start;
  logic       req_nxt;
  logic       we_nxt;
  logic       cwe_nxt;

  // Reset masks the miss term so stall stays low while rst_i is asserted.
  assign miss    = (MemRead_i | MemWrite_i) & ~hit_i & rst_i;
  assign stall_o = (state != IDLE) | miss;
  assign in_wait = (state == WRITEBACK) | (state == REFILL);
  assign start   = (state == IDLE) & miss;

  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (miss) next_state = dirty_i ? WRITEBACK : REFILL;
      WRITEBACK: if (mem_ready_i) next_state = REFILL;
      REFILL:    if (mem_ready_i) next_state = UPDATE;
      UPDATE:    next_state = IDLE;
      default:   next_state = IDLE;
    endcase

    req_nxt = (next_state == WRITEBACK) | (next_state == REFILL);
    we_nxt  = (next_state == WRITEBACK);
    cwe_nxt = (next_state == UPDATE);

    enter_wait = (next_state != state) &
                 ((next_state == WRITEBACK) | (next_state == REFILL));

    wait_cnt_nxt = wait_cnt;
    if (enter_wait) begin
      wait_cnt_nxt = 8'd0;
    end else if (in_wait && !mem_ready_i && wait_cnt != 8'hFF) begin
      wait_cnt_nxt = wait_cnt + 8'd1;
    end

    // Sticky: the FSM keeps waiting after the flag is raised.
    timeout_nxt = timeout_o | (in_wait & ~enter_wait & (wait_cnt_nxt >= TO_LIM));
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      mem_req_o  <= 1'b0;
      mem_we_o   <= 1'b0;
      cache_we_o <= 1'b0;
      timeout_o  <= 1'b0;
      wait_cnt   <= 8'd0;
      miss_cnt_o <= '0;
    end else begin
      state      <= next_state;
      mem_req_o  <= req_nxt;
      mem_we_o   <= we_nxt;
      cache_we_o <= cwe_nxt;
      timeout_o  <= timeout_nxt;
      wait_cnt   <= wait_cnt_nxt;
      if (start && miss_cnt_o != {CNT_W{1'b1}}) begin
        miss_cnt_o <= miss_cnt_o + CNT_W'(1);
      end
    end
  end

endmodule
